dec_scheduler: RTL and testbench

Round-robin scheduler that shares a single multi-cycle binary-to-BCD engine between several 12-bit requesters, such as the ADC channel readers feeding the text/display path. Each request is arbitrated and its value captured. The scheduler runs the double-dabble sequence, then returns four ASCII digits tagged with the requester index plus a one-cycle acknowledge to the winner. It sits between the per-channel sample producers and the screen/UART text formatters.

---
 rtl/dec_pkg.sv | 16 +
 rtl/dec_bcd_step.sv | 22 ++
 rtl/dec_scheduler.sv | 114 +++++++++++
 tb/tb_dec_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared types and constants for the decimal conversion scheduler
package dec_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_DONE    = 2'd2
   } dec_state_t;

   localparam int         DATA_WIDTH = 12;
   localparam int         BCD_WIDTH  = 16;
   localparam int         STEP_WIDTH = 4;
   localparam int         LAST_STEP  = 11;
   localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/dec_bcd_step.sv
// rtl/dec_bcd_step.sv - one double-dabble iteration: add-3 correction then shift in one bit
module dec_bcd_step
   import dec_pkg::*;
(
   input  logic [BCD_WIDTH-1:0] digits,
   input  logic                 bit_in,
   output logic [BCD_WIDTH-1:0] digits_next
);

   logic [BCD_WIDTH-1:0] corrected;

   always_comb begin
      corrected = digits;
      for (int n = 0; n < BCD_WIDTH / 4; n++) begin
         if (digits[4*n +: 4] >= 4'd5) begin
            corrected[4*n +: 4] = digits[4*n +: 4] + 4'd3;
         end
      end
      digits_next = {corrected[BCD_WIDTH-2:0], bit_in};
   end

endmodule

// File: rtl/dec_scheduler.sv
// rtl/dec_scheduler.sv - round-robin sharing of one binary-to-BCD engine among 12-bit requesters
module dec_scheduler
   import dec_pkg::*;
#(
   parameter  int CHANNELS = 4,
   localparam int CW       = $clog2(CHANNELS)
)(
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [CHANNELS-1:0]            req,
   input  logic [DATA_WIDTH*CHANNELS-1:0] value,
   output logic [CHANNELS-1:0]            ack,
   output logic                           busy,
   output logic                           resultValid,
   output logic [CW-1:0]                  resultChannel,
   output logic [7:0]                     thousands,
   output logic [7:0]                     hundreds,
   output logic [7:0]                     tens,
   output logic [7:0]                     units
);

   localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);

   dec_state_t             state;
   logic [CW-1:0]          rr_ptr;
   logic [CW-1:0]          granted;
   logic [DATA_WIDTH-1:0]  shift_reg;
   logic [BCD_WIDTH-1:0]   digits;
   logic [BCD_WIDTH-1:0]   digits_next;
   logic [STEP_WIDTH-1:0]  step;

   logic                   grant_any;
   logic [CW-1:0]          grant_idx;
   logic [DATA_WIDTH-1:0]  grant_value;
   int                     cand;

   // First set request at or above rr_ptr, wrapping; the last winner sits at the bottom.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      cand      = 0;
      for (int k = 0; k < CHANNELS; k++) begin
         cand = (int'(rr_ptr) + k) % CHANNELS;
         if (!grant_any && req[CW'(cand)]) begin
            grant_any = 1'b1;
            grant_idx = CW'(cand);
         end
      end
      grant_value = value[DATA_WIDTH*int'(grant_idx) +: DATA_WIDTH];
   end

   dec_bcd_step u_step (
      .digits      (digits),
      .bit_in      (shift_reg[DATA_WIDTH-1]),
      .digits_next (digits_next)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_IDLE;
         rr_ptr        <= '0;
         granted       <= '0;
         shift_reg     <= '0;
         digits        <= '0;
         step          <= '0;
         busy          <= 1'b0;
         ack           <= '0;
         resultValid   <= 1'b0;
         resultChannel <= '0;
         thousands     <= ASCII_ZERO;
         hundreds      <= ASCII_ZERO;
         tens          <= ASCII_ZERO;
         units         <= ASCII_ZERO;
      end else begin
         ack         <= '0;
         resultValid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_any) begin
                  granted   <= grant_idx;
                  shift_reg <= grant_value;
                  digits    <= '0;
                  step      <= '0;
                  busy      <= 1'b1;
                  state     <= S_CONVERT;
               end
            end
            S_CONVERT: begin
               digits    <= digits_next;
               shift_reg <= shift_reg << 1;
               if (step == STEP_WIDTH'(LAST_STEP)) begin
                  state <= S_DONE;
               end else begin
                  step <= step + 1'b1;
               end
            end
            S_DONE: begin
               thousands     <= ASCII_ZERO + {4'd0, digits[15:12]};
               hundreds      <= ASCII_ZERO + {4'd0, digits[11:8]};
               tens          <= ASCII_ZERO + {4'd0, digits[7:4]};
               units         <= ASCII_ZERO + {4'd0, digits[3:0]};
               resultChannel <= granted;
               resultValid   <= 1'b1;
               ack           <= ONE_HOT0 << granted;
               busy          <= 1'b0;
               rr_ptr        <= (granted == CW'(CHANNELS - 1)) ? '0 : granted + 1'b1;
               state         <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dec_scheduler.sv
// tb/tb_dec_scheduler.sv - directed self-checking bench for dec_scheduler
module tb_dec_scheduler;

   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [CH-1:0] req = '0;
   logic [47:0]   value = '0;
   logic [CH-1:0] ack;
   logic          busy;
   logic          resultValid;
   logic [1:0]    resultChannel;
   logic [7:0]    thousands, hundreds, tens, units;

   int vectors = 0;
   int miscompares = 0;

   dec_scheduler #(.CHANNELS(CH)) dut (
      .clk           (clk),
      .resetn        (resetn),
      .req           (req),
      .value         (value),
      .ack           (ack),
      .busy          (busy),
      .resultValid   (resultValid),
      .resultChannel (resultChannel),
      .thousands     (thousands),
      .hundreds      (hundreds),
      .tens          (tens),
      .units         (units)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      req    = '0;
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   // Negedges until resultValid is seen, or -1 after 40 cycles.
   task automatic wait_result(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (resultValid) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++;
      if ({busy, resultValid, ack, resultChannel} !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_ctrl got busy=%b rv=%b ack=%b ch=%0d want all 0", busy, resultValid, ack, resultChannel);
      end
      vectors++;
      if ({thousands, hundreds, tens, units} !== 32'h30303030) begin
         miscompares++;
         $display("FAIL reset_digits got %h want 30303030", {thousands, hundreds, tens, units});
      end
   endtask

   task automatic test_single();
      apply_reset();
      value[11:0] = 12'd1234;
      req = 4'b0001;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         vectors++;
         if (busy !== (i <= 13)) begin
            miscompares++;
            $display("FAIL single_busy cycle %0d got %b want %b", i, busy, (i <= 13));
         end
      end
      vectors++;
      if ({resultValid, ack, resultChannel} !== {1'b1, 4'b0001, 2'd0}) begin
         miscompares++;
         $display("FAIL single_result got rv=%b ack=%b ch=%0d want 1/0001/0", resultValid, ack, resultChannel);
      end
      vectors++;
      if ({thousands, hundreds, tens, units} !== "1234") begin
         miscompares++;
         $display("FAIL single_digits got %h want %h", {thousands, hundreds, tens, units}, "1234");
      end
      req = '0;
      @(negedge clk);
      vectors++;
      if ({resultValid, ack} !== 5'b0) begin
         miscompares++;
         $display("FAIL single_pulse got rv=%b ack=%b want 0/0000", resultValid, ack);
      end
   endtask

   task automatic test_boundaries();
      logic [11:0] vals [2];
      logic [31:0] exp [2];
      int          n;
      vals = '{12'd0, 12'd4095};
      exp  = '{"0000", "4095"};
      apply_reset();
      for (int t = 0; t < 2; t++) begin
         value[35:24] = vals[t];
         req = 4'b0100;
         wait_result(n);
         vectors++;
         if (n !== 14 || resultChannel !== 2'd2 || ack !== 4'b0100) begin
            miscompares++;
            $display("FAIL bound_ctrl_%0d got lat=%0d ch=%0d ack=%b want 14/2/0100", t, n, resultChannel, ack);
         end
         vectors++;
         if ({thousands, hundreds, tens, units} !== exp[t]) begin
            miscompares++;
            $display("FAIL bound_digits_%0d got %h want %h", t, {thousands, hundreds, tens, units}, exp[t]);
         end
         req = '0;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [4];
      int          n;
      exp = '{"0001", "0022", "0333", "4000"};
      apply_reset();
      value = {12'd4000, 12'd333, 12'd22, 12'd1};
      req = 4'b1111;
      for (int c = 0; c < 4; c++) begin
         wait_result(n);
         vectors++;
         if (n !== 14 || resultChannel !== 2'(c) || ack !== (4'b0001 << c)) begin
            miscompares++;
            $display("FAIL b2b_ctrl_%0d got lat=%0d ch=%0d ack=%b want 14/%0d", c, n, resultChannel, ack, c);
         end
         vectors++;
         if ({thousands, hundreds, tens, units} !== exp[c]) begin
            miscompares++;
            $display("FAIL b2b_digits_%0d got %h want %h", c, {thousands, hundreds, tens, units}, exp[c]);
         end
         req[c] = 1'b0;
      end
   endtask

   task automatic test_fairness();
      int order [4];
      int n;
      order = '{1, 3, 1, 1};
      apply_reset();
      value = {12'd9, 12'd0, 12'd7, 12'd0};
      req = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         wait_result(n);
         vectors++;
         if (n !== 14 || resultChannel !== 2'(order[k])) begin
            miscompares++;
            $display("FAIL fair_%0d got lat=%0d ch=%0d want 14/%0d", k, n, resultChannel, order[k]);
         end
         if (ack[3]) req[3] = 1'b0;
      end
      req = '0;
      @(negedge clk);
   endtask

   task automatic test_grant_final();
      int n;
      int pulses;
      apply_reset();
      value[11:0] = 12'd1234;
      req = 4'b0001;
      repeat (3) @(negedge clk);
      value[11:0] = 12'd999;
      req = '0;
      wait_result(n);
      vectors++;
      if (n !== 11 || ack !== 4'b0001) begin
         miscompares++;
         $display("FAIL final_ctrl got lat=%0d ack=%b want 11/0001", n, ack);
      end
      vectors++;
      if ({thousands, hundreds, tens, units} !== "1234") begin
         miscompares++;
         $display("FAIL final_digits got %h want %h", {thousands, hundreds, tens, units}, "1234");
      end
      pulses = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resultValid || ack != '0 || busy) pulses++;
      end
      vectors++;
      if (pulses !== 0) begin
         miscompares++;
         $display("FAIL withdrawn_idle got %0d active cycles want 0", pulses);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      apply_reset();
      value = {12'd0, 12'd0, 12'd55, 12'd1234};
      req = 4'b0011;
      wait_result(n);
      vectors++;
      if (n !== 14 || resultChannel !== 2'd0) begin
         miscompares++;
         $display("FAIL rmid_first got lat=%0d ch=%0d want 14/0", n, resultChannel);
      end
      repeat (7) @(negedge clk);
      resetn = 1'b0;
      #1;
      vectors++;
      if ({busy, resultValid, ack, resultChannel} !== 8'h00 || {thousands, hundreds, tens, units} !== 32'h30303030) begin
         miscompares++;
         $display("FAIL rmid_abort got busy=%b rv=%b ack=%b ch=%0d digits=%h want 0s/30303030",
                  busy, resultValid, ack, resultChannel, {thousands, hundreds, tens, units});
      end
      @(negedge clk);
      resetn = 1'b1;
      wait_result(n);
      vectors++;
      if (n !== 14 || resultChannel !== 2'd0 || ack !== 4'b0001 ||
          {thousands, hundreds, tens, units} !== "1234") begin
         miscompares++;
         $display("FAIL rmid_restart got lat=%0d ch=%0d ack=%b digits=%h want 14/0/0001/%h",
                  n, resultChannel, ack, {thousands, hundreds, tens, units}, "1234");
      end
      req = '0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_boundaries();
      test_back_to_back();
      test_fairness();
      test_grant_final();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
